// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer for the single-cycle MIPS core.
// Owns the PC and drives the 64-entry combinational-read instruction memory.
// It handles boot delay, redirects, stalls with a deferred redirect, and halt.
// Optional build macro FETCH_COUNT_EN adds a 32-bit fetch_count output.
// That output counts consumed instructions.

module imem_fetch_sequencer #(
  parameter int unsigned          ADDR_W      = 6,
  parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
  parameter int unsigned          BOOT_CYCLES = 4,
  parameter logic [31:0]          HALT_WORD   = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  output logic [31:0]       instr_out,
  output logic              instr_valid,
  output logic [ADDR_W+1:0] pc_byte,
  output logic              halted
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  typedef enum logic [1:0] {StBoot, StRun, StStall, StHalt} state_e;

  localparam logic [3:0] BootLast = 4'(BOOT_CYCLES - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [3:0]        boot_cnt_q;
  logic [31:0]       hold_q;
  logic [ADDR_W-1:0] pend_q;
  logic              pend_valid_q;
  logic              instr_valid_q;
  logic              halted_q;
  logic              halt_now;

  // A halt word or an external request both stop the sequencer while running.
  assign halt_now = halt_req || (imem_instr == HALT_WORD);

  // Address and decoder-facing outputs; only RUN passes the memory word straight through.
  always_comb begin
    imem_addr   = pc_q;
    pc_byte     = {pc_q, 2'b00};
    instr_out   = (state_q == StRun) ? imem_instr : hold_q;
    instr_valid = instr_valid_q;
    halted      = halted_q;
  end

  // Sequencer FSM with PC, hold register, pending redirect and registered flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      boot_cnt_q    <= 4'd0;
      hold_q        <= 32'd0;
      pend_q        <= '0;
      pend_valid_q  <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StBoot: begin
          if (boot_cnt_q == BootLast) begin
            state_q       <= StRun;
            instr_valid_q <= 1'b1;
          end else begin
            boot_cnt_q <= boot_cnt_q + 4'd1;
          end
        end
        StRun: begin
          if (halt_now) begin
            state_q       <= StHalt;
            hold_q        <= imem_instr;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b1;
          end else if (stall) begin
            state_q <= StStall;
            hold_q  <= imem_instr;
            if (redirect) begin
              pend_q       <= redirect_target;
              pend_valid_q <= 1'b1;
            end
          end else if (redirect) begin
            pc_q <= redirect_target;
          end else begin
            pc_q <= pc_q + ADDR_W'(1);
          end
        end
        StStall: begin
          if (halt_req) begin
            state_q       <= StHalt;
            pend_valid_q  <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b1;
          end else if (stall) begin
            // Latest redirect seen during the stall wins.
            if (redirect) begin
              pend_q       <= redirect_target;
              pend_valid_q <= 1'b1;
            end
          end else begin
            state_q      <= StRun;
            pend_valid_q <= 1'b0;
            if (redirect) begin
              pc_q <= redirect_target;
            end else if (pend_valid_q) begin
              pc_q <= pend_q;
            end else begin
              pc_q <= pc_q + ADDR_W'(1);
            end
          end
        end
        StHalt: begin
          // Frozen until reset.
        end
        default: begin
          state_q <= StBoot;
        end
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  logic        advance;
  logic [31:0] fetch_count_q;

  // An instruction is consumed on an advancing RUN cycle or on the stall-exit cycle.
  assign advance = ((state_q == StRun) && !halt_now && !stall) ||
                   ((state_q == StStall) && !halt_req && !stall);

  // Free-running consumed-instruction counter, wraps at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= 32'd0;
    end else if (advance) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule
